serializer_fsm: RTL and testbench
=================================

Name: serializer_fsm

Overview:
Parallel-to-serial converter for the FIR filter datapath. It accepts one LENGTH-bit word from the FIR output stage through a valid/ready handshake. It then shifts the word out LSB-first, one bit per accepted transfer, under a per-bit valid/ready handshake with the downstream receiver (testbench or a deserializer). It sits between the FIR output and the serial output pin, and is the transmit counterpart of the serial-input deserializer.

Parameters:
- LENGTH, 24, word width in bits; legal range ≥ 2.

Ports:
- i_clk, input, 1, single clock; all logic on the rising edge.
- i_rst, input, 1, synchronous, active-high reset; overrides i_en.
- i_en, input, 1, clock enable; when low, all state, counters and outputs hold.
- iv_din, input, LENGTH, parallel word from the FIR.
- i_din_valid, input, 1, iv_din is valid.
- o_ready, output, 1, serializer can accept a word (to FIR).
- o_dout, output, 1, serial data bit.
- o_dout_valid, output, 1, o_dout holds a valid bit.
- i_ready, input, 1, receiver accepts the current bit.

Behaviour:
- All outputs are registered.
- Reset values: o_ready=0, o_dout=0, o_dout_valid=0, shift register=0, bit counter=0, state=S_IDLE.
- Bit counter width: $clog2(LENGTH+1)+1.
- Word accept: occurs on a rising edge with i_en=1, o_ready=1 and i_din_valid=1.
- Bit transfer: occurs on a rising edge with i_en=1, o_dout_valid=1 and i_ready=1.
- States:
  - S_IDLE:
    - o_ready=1 (asserted one cycle after entering), o_dout_valid=0, o_dout=0.
    - On word accept: latch iv_din, o_ready<=0, counter<=0, go to S_SHIFT.
    - i_din_valid while o_ready=0 is ignored; the FIR must hold its word.
  - S_SHIFT:
    - o_dout_valid=1; o_dout = bit[counter] of the latched word, starting at bit 0.
    - On a transfer: shift right, counter+1, o_dout<=next bit.
    - No transfer (i_ready=0): o_dout and o_dout_valid hold stable (no bit is dropped or repeated).
    - The transfer of bit LENGTH-1 goes to S_DONE with o_dout_valid<=0, o_dout<=0.
  - S_DONE:
    - One-cycle gap, o_ready=0; next edge go to S_IDLE with o_ready<=1.
  - Illegal state encoding: go to S_IDLE next edge.
- Latency and throughput:
  - First bit is visible on the cycle after the accept edge.
  - With i_ready tied high, LENGTH bits appear on LENGTH consecutive cycles.
  - Word-to-word period is LENGTH+2 cycles.
- i_en=0 mid-word: everything freezes, and no transfers or accepts are counted even if i_ready or i_din_valid are high. Resumes exactly where it stopped.
- Reset mid-word: the partial word is discarded; outputs go to reset values on the next edge; no further bits are emitted.
- i_din_valid and i_ready high simultaneously in S_IDLE: only the accept takes effect; the first bit transfer can occur no earlier than the following edge.
- Changing iv_din after accept has no effect on the word in flight.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - After bit LENGTH-1, one extra bit is sent under the same handshake: the even parity bit (XOR of all LENGTH data bits).
  - The transfer of the parity bit, not bit LENGTH-1, moves to S_DONE.
  - Word period with i_ready high is LENGTH+3.
- Undefined: exactly LENGTH bits per word, no parity logic synthesized.

Test Plan:
- Reset: hold i_rst 3 cycles with i_din_valid=1 and i_ready=1 -> o_ready=0, o_dout_valid=0, o_dout=0 throughout; o_ready=1 on the second cycle after reset release.
- Single word, i_ready=1: iv_din=24'h00003C -> o_dout_valid high for exactly 24 cycles. o_dout sequence 0,0,1,1,1,1 then 18 zeros. o_ready high again 26 cycles after the accept edge.
- Back-pressure: iv_din=24'hA5A5A5, i_ready low on every other cycle -> 24 transfers over ~48 cycles. Reassembled bits = 24'hA5A5A5, o_dout stable during every stall.
- Enable gating: drop i_en for 5 cycles after bit 7 -> outputs frozen, no counter advance; resume yields the full correct word.
- Mid-word reset: assert i_rst after bit 10 of 24'hFFFFFF -> o_dout_valid=0 on the next edge. A new word 24'h123456 afterwards serializes correctly.
- Loopback plus parity: back-to-back words 24'h000001, 24'h800000, 24'hFFFFFF into the serial-input deserializer -> identical words recovered. With SERIALIZER_PARITY_EN, the 25th bits are 1, 1, 0 respectively.

Source files
------------

// File: rtl/serializer_fsm.sv
// LSB-first parallel-to-serial converter with valid/ready handshakes on both sides.
// Define SERIALIZER_PARITY_EN to append an even parity bit after each word.
module serializer_fsm #(
  parameter int LENGTH = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [LENGTH-1:0] iv_din,
  input  logic              i_din_valid,
  output logic              o_ready,
  output logic              o_dout,
  output logic              o_dout_valid,
  input  logic              i_ready
);

  localparam int CW = $clog2(LENGTH + 1) + 1;
`ifdef SERIALIZER_PARITY_EN
  localparam int LAST = LENGTH;
`else
  localparam int LAST = LENGTH - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [LENGTH-1:0] r_shreg, w_shreg_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic              w_ready_nxt, w_dout_nxt, w_valid_nxt;
`ifdef SERIALIZER_PARITY_EN
  logic              r_par, w_par_nxt;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_cnt        <= '0;
      o_ready      <= 1'b0;
      o_dout       <= 1'b0;
      o_dout_valid <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_par        <= 1'b0;
`endif
    end else if (i_en) begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_cnt        <= w_cnt_nxt;
      o_ready      <= w_ready_nxt;
      o_dout       <= w_dout_nxt;
      o_dout_valid <= w_valid_nxt;
`ifdef SERIALIZER_PARITY_EN
      r_par        <= w_par_nxt;
`endif
    end
  end

  // r_shreg holds the bits not yet presented; o_dout is the bit on the wire.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = o_ready;
    w_dout_nxt  = o_dout;
    w_valid_nxt = o_dout_valid;
`ifdef SERIALIZER_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        if (!o_ready) begin
          w_ready_nxt = 1'b1;
        end else if (i_din_valid) begin
          w_shreg_nxt = iv_din >> 1;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b0;
          w_dout_nxt  = iv_din[0];
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SHIFT;
`ifdef SERIALIZER_PARITY_EN
          w_par_nxt   = ^iv_din;
`endif
        end
      end
      S_SHIFT: begin
        if (o_dout_valid && i_ready) begin
          if (r_cnt == CW'(LAST)) begin
            w_state_nxt = S_DONE;
            w_valid_nxt = 1'b0;
            w_dout_nxt  = 1'b0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_shreg_nxt = r_shreg >> 1;
            w_dout_nxt  = r_shreg[0];
`ifdef SERIALIZER_PARITY_EN
            if (r_cnt == CW'(LENGTH - 1))
              w_dout_nxt = r_par;
`endif
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b0;
        w_dout_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serializer_fsm.sv
// Self-checking bench for serializer_fsm: directed scenarios plus random traffic
// checked every cycle against a queue-based protocol model.
module tb_serializer_fsm;

  localparam int L = 24;
`ifdef SERIALIZER_PARITY_EN
  localparam int NBITS = L + 1;
`else
  localparam int NBITS = L;
`endif

  logic         clk = 1'b0;
  logic         i_rst, i_en, i_din_valid, i_ready;
  logic [L-1:0] iv_din;
  logic         o_ready, o_dout, o_dout_valid;

  always #5 clk = ~clk;

  serializer_fsm #(.LENGTH(L)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .iv_din      (iv_din),
    .i_din_valid (i_din_valid),
    .o_ready     (o_ready),
    .o_dout      (o_dout),
    .o_dout_valid(o_dout_valid),
    .i_ready     (i_ready)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  bit           q[$];
  logic [L-1:0] wq[$];
  bit           m_rdy   = 1'b0;
  int           n_acc   = 0;
  int           cyc     = 0;
  int           acc_cyc = 0;
  int           last_period = 0;
  int           rx_cnt  = 0;
  logic [L-1:0] rx_word = '0;
  bit           par_seen[$];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step(bit rst, bit en, logic [L-1:0] d, bit v, bit r);
    bit obs;
    @(negedge clk);
    chk("o_ready", 32'(o_ready), 32'(m_rdy));
    chk("o_dout_valid", 32'(o_dout_valid), 32'(q.size() > 0));
    chk("o_dout", 32'(o_dout), 32'((q.size() > 0) ? q[0] : 1'b0));
    obs = o_dout;
    i_rst = rst; i_en = en; iv_din = d; i_din_valid = v; i_ready = r;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete(); wq.delete();
      m_rdy = 1'b0; rx_cnt = 0;
    end else if (en) begin
      if (m_rdy && v) begin
        for (int i = 0; i < L; i++) q.push_back(d[i]);
`ifdef SERIALIZER_PARITY_EN
        q.push_back(^d);
`endif
        wq.push_back(d);
        m_rdy = 1'b0; rx_cnt = 0; rx_word = '0;
        n_acc++;
        last_period = cyc - acc_cyc;
        acc_cyc = cyc;
      end else if (q.size() > 0 && r) begin
        if (rx_cnt < L) rx_word[rx_cnt] = obs;
        else par_seen.push_back(obs);
        rx_cnt++;
        void'(q.pop_front());
        if (q.size() == 0) chk("word", 32'(rx_word), 32'(wq.pop_front()));
      end else if (q.size() == 0 && !m_rdy) begin
        m_rdy = 1'b1;
      end
    end
  endtask

  // mode 0: ready high, 1: ready alternating, 2: enable gap after bit 7, 3: random ready
  task automatic run_word(logic [L-1:0] d, int mode, int max_cyc);
    int  a0 = n_acc;
    int  i  = 0;
    int  stop = 0;
    bit  en, r;
    while ((n_acc == a0 || q.size() > 0) && i < max_cyc) begin
      en = 1'b1; r = 1'b1;
      if (mode == 1) r = (i % 2 == 0);
      if (mode == 2 && n_acc != a0 && rx_cnt == 8 && stop < 5) begin
        en = 1'b0; stop++;
      end
      if (mode == 3) r = ($urandom_range(0, 2) != 0);
      step(1'b0, en, d, n_acc == a0, r);
      i++;
    end
    chk("timeout", 32'(i >= max_cyc), 32'(0));
  endtask

  initial begin
    i_rst = 1'b1; i_en = 1'b1; iv_din = '0; i_din_valid = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    chk("ready_after_rst", 32'(o_ready), 32'(1));

    run_word(24'h00003C, 0, 200);
    run_word(24'hA5A5A5, 1, 200);
    run_word(24'h5A0F3C, 2, 200);

    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, 24'hFFFFFF, n_acc == 0 || !o_dout_valid, 1'b1);
    step(1'b1, 1'b1, 24'hFFFFFF, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, 1'b0, 1'b1);
    run_word(24'h123456, 0, 200);

    par_seen.delete();
    run_word(24'h000001, 0, 200);
    run_word(24'h800000, 0, 200);
    chk("period", 32'(last_period), 32'(NBITS + 2));
    run_word(24'hFFFFFF, 0, 200);
    chk("period2", 32'(last_period), 32'(NBITS + 2));
`ifdef SERIALIZER_PARITY_EN
    chk("par_cnt", 32'(par_seen.size()), 32'(3));
    if (par_seen.size() == 3) begin
      chk("par0", 32'(par_seen[0]), 32'(1));
      chk("par1", 32'(par_seen[1]), 32'(1));
      chk("par2", 32'(par_seen[2]), 32'(0));
    end
`endif

    for (int k = 0; k < 20; k++) run_word(L'($urandom), 3, 400);

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 5) != 0,
           L'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
